// File: rtl/dut_sched_pkg.sv
// Shared definitions for the dut_sched scheduler: datapath widths, the NOOP opcode,
// the scheduler state type and the opcode-supported check.
package dut_sched_pkg;

    localparam int unsigned NUM_SIZE      = 8;
    localparam int unsigned CMD_SIZE_LOG2 = 2;
    localparam int unsigned CMD_W         = 2 ** CMD_SIZE_LOG2;

    localparam logic [CMD_W-1:0] NOOP = '0;

    typedef enum logic [1:0] {SCHED_IDLE, SCHED_EXEC, SCHED_RESP} sched_state_t;

    // Only NOOP is currently issued to the datapath; everything else is rejected.
    function automatic logic cmd_supported(input logic [CMD_W-1:0] cmd);
        return cmd == NOOP;
    endfunction

endpackage

// File: rtl/dut_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after the pointer, wrapping,
// returned both as a one-hot grant and as an index.
module dut_sched_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int unsigned IdW = $clog2(N);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = IdW'(j);
            end
        end
    end

endmodule

// File: rtl/dut_sched.sv
// Round-robin scheduler sharing one arithmetic datapath between NUM_REQ requesters.
// Optional per-requester handshake counters on stat_grants when DUT_SCHED_STATS_EN is defined.
module dut_sched
    import dut_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DUT_LAT = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][NUM_SIZE-1:0]   req_in1,
    input  logic [NUM_REQ-1:0][NUM_SIZE-1:0]   req_in2,
    input  logic [NUM_REQ-1:0][CMD_W-1:0]      req_cmd,
    output logic signed [NUM_SIZE-1:0]         dut_in1,
    output logic signed [NUM_SIZE-1:0]         dut_in2,
    output logic [CMD_W-1:0]                   dut_cmd,
    input  logic                               dut_out,
    output logic                               resp_valid,
    input  logic                               resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         resp_id,
    output logic                               resp_data,
    output logic                               resp_err
`ifdef DUT_SCHED_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]           stat_grants
`endif
);

    localparam int unsigned IdW  = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(DUT_LAT + 2);

    sched_state_t       state;
    logic [IdW-1:0]     rr_ptr;
    logic [IdW-1:0]     grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic               grant_found;
    logic [CntW-1:0]    exec_cnt;

    dut_sched_rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .grant(grant),
        .idx  (grant_idx),
        .found(grant_found)
    );

    // Gated by reset_n so nothing is accepted while reset is being sampled.
    assign req_ready = (state == SCHED_IDLE && reset_n) ? grant : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= SCHED_IDLE;
            rr_ptr     <= '0;
            exec_cnt   <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= 1'b0;
            resp_err   <= 1'b0;
            dut_in1    <= '0;
            dut_in2    <= '0;
            dut_cmd    <= NOOP;
        end else begin
            unique case (state)
                SCHED_IDLE: begin
                    if (grant_found) begin
                        resp_id <= grant_idx;
                        if (cmd_supported(req_cmd[grant_idx])) begin
                            dut_in1  <= req_in1[grant_idx];
                            dut_in2  <= req_in2[grant_idx];
                            dut_cmd  <= req_cmd[grant_idx];
                            exec_cnt <= '0;
                            state    <= SCHED_EXEC;
                        end else begin
                            resp_err   <= 1'b1;
                            resp_data  <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= SCHED_RESP;
                        end
                    end
                end
                SCHED_EXEC: begin
                    if (exec_cnt == CntW'(DUT_LAT)) begin
                        resp_data  <= dut_out;
                        resp_valid <= 1'b1;
                        state      <= SCHED_RESP;
                    end else begin
                        exec_cnt <= exec_cnt + CntW'(1);
                    end
                end
                SCHED_RESP: begin
                    if (resp_ready) begin
                        rr_ptr     <= (resp_id == IdW'(NUM_REQ - 1)) ? '0 : resp_id + IdW'(1);
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        dut_cmd    <= NOOP;
                        state      <= SCHED_IDLE;
                    end
                end
                default: state <= SCHED_IDLE;
            endcase
        end
    end

`ifdef DUT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_grants <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && stat_grants[i] != 16'hFFFF) begin
                    stat_grants[i] <= stat_grants[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_dut_sched.sv
// Directed self-checking bench for dut_sched (NUM_REQ=4, DUT_LAT=1).
module tb_dut_sched;
    import dut_sched_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset_n;
    logic [3:0]                      req_valid;
    logic [3:0]                      req_ready;
    logic [3:0][NUM_SIZE-1:0]        req_in1;
    logic [3:0][NUM_SIZE-1:0]        req_in2;
    logic [3:0][CMD_W-1:0]           req_cmd;
    logic signed [NUM_SIZE-1:0]      dut_in1;
    logic signed [NUM_SIZE-1:0]      dut_in2;
    logic [CMD_W-1:0]                dut_cmd;
    logic                            dut_out;
    logic                            resp_valid;
    logic                            resp_ready;
    logic [1:0]                      resp_id;
    logic                            resp_data;
    logic                            resp_err;
`ifdef DUT_SCHED_STATS_EN
    logic [3:0][15:0]                stat_grants;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dut_sched #(
        .NUM_REQ(4),
        .DUT_LAT(1)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_cmd    (req_cmd),
        .dut_in1    (dut_in1),
        .dut_in2    (dut_in2),
        .dut_cmd    (dut_cmd),
        .dut_out    (dut_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
`ifdef DUT_SCHED_STATS_EN
        ,
        .stat_grants(stat_grants)
`endif
    );

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
        dut_out    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Complete one supported command from requester id with the response consumed.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic o);
        int n;
        @(negedge clk);
        req_valid   = 4'b0001 << id;
        req_in1[id] = a;
        req_in2[id] = b;
        req_cmd[id] = NOOP;
        resp_ready  = 1'b0;
        @(negedge clk);
        req_valid = 4'b0000;
        dut_out   = o;
        n = 0;
        #1;
        while (!resp_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (resp_valid !== 1'b1) begin
            bad++;
            $display("FAIL op_timeout: resp_valid=%b want 1", resp_valid);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        dut_out    = 1'b0;
        req_in1    = '0;
        req_in2    = '0;
        req_cmd    = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_req_ready: got %b want 0000", req_ready);
        end
        total++;
        if ({resp_valid, resp_id, resp_data, resp_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_resp: got %b want 00000", {resp_valid, resp_id, resp_data, resp_err});
        end
        total++;
        if (dut_cmd !== NOOP || dut_in1 !== 8'sd0 || dut_in2 !== 8'sd0) begin
            bad++;
            $display("FAIL reset_dut_regs: cmd=%h in1=%h in2=%h want %h 00 00",
                     dut_cmd, dut_in1, dut_in2, NOOP);
        end
        req_valid = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_op();
        @(negedge clk);
        req_valid  = 4'b0001;
        req_in1[0] = 8'd3;
        req_in2[0] = 8'hFE;
        req_cmd[0] = NOOP;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        dut_out   = 1'b0;
        #1;
        total++;
        if (dut_in1 !== 8'sd3 || dut_in2 !== 8'hFE || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL single_operands: in1=%h in2=%h ready=%b want 03 fe 0000",
                     dut_in1, dut_in2, req_ready);
        end
        @(negedge clk);
        dut_out = 1'b1;
        #1;
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early_valid: got %b want 0", resp_valid);
        end
        @(negedge clk);
        dut_out = 1'b0;
        #1;
        total++;
        if ({resp_valid, resp_id, resp_data, resp_err} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_resp: got %b want 10010", {resp_valid, resp_id, resp_data, resp_err});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        total++;
        if (resp_valid !== 1'b0 || dut_cmd !== NOOP) begin
            bad++;
            $display("FAIL single_release: valid=%b cmd=%h want 0 %h", resp_valid, dut_cmd, NOOP);
        end
    endtask

    task automatic test_fairness();
        int n;
        logic [3:0] exp_rdy;
        do_reset();
        @(negedge clk);
        req_cmd    = '0;
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n = 0;
            while (req_ready == 4'b0000 && n < 10) begin
                @(negedge clk);
                #1;
                n++;
            end
            exp_rdy = 4'b0001 << (k % 4);
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL fair_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
            end
            if (k > 0) begin
                total++;
                if (n != 3) begin
                    bad++;
                    $display("FAIL fair_gap[%0d]: got %0d want 3", k, n);
                end
            end
            @(negedge clk);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_back_pressure();
        do_reset();
        @(negedge clk);
        req_valid  = 4'b0010;
        req_in1[1] = 8'd5;
        req_in2[1] = 8'd6;
        req_cmd[1] = NOOP;
        resp_ready = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_grant: got %b want 0010", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b1111;
        dut_out   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        dut_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++;
            if ({resp_valid, resp_id, resp_data, resp_err, req_ready, dut_in1} !==
                {1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 8'd5}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got %h want %h", i,
                         {resp_valid, resp_id, resp_data, resp_err, req_ready, dut_in1},
                         {1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 8'd5});
            end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bp_next_grant: got %b want 0100", req_ready);
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
    endtask

    task automatic test_bad_opcode();
        do_reset();
        run_op(1, 8'd9, 8'd4, 1'b1);
        @(negedge clk);
        req_valid  = 4'b0100;
        req_in1[2] = 8'd7;
        req_cmd[2] = 4'(NOOP + 4'd1);
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL bad_grant: got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid  = 4'b1111;
        req_cmd[2] = NOOP;
        #1;
        total++;
        if ({resp_valid, resp_err, resp_id, resp_data} !== {1'b1, 1'b1, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL bad_resp: got %b want 11100", {resp_valid, resp_err, resp_id, resp_data});
        end
        total++;
        if (dut_in1 !== 8'sd9 || dut_cmd !== NOOP || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bad_dut_untouched: in1=%h cmd=%h ready=%b want 09 %h 0000",
                     dut_in1, dut_cmd, req_ready, NOOP);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (req_ready !== 4'b1000 || resp_err !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL bad_release: ready=%b err=%b valid=%b want 1000 0 0",
                     req_ready, resp_err, resp_valid);
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        logic seen;
        do_reset();
        run_op(1, 8'd1, 8'd1, 1'b0);
        @(negedge clk);
        req_valid  = 4'b0100;
        req_in1[2] = 8'd11;
        req_cmd[2] = NOOP;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL mid_grant: got %b want 0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        reset_n   = 1'b0;
        dut_out   = 1'b1;
        @(negedge clk);
        reset_n    = 1'b1;
        resp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_resp: resp_valid seen=%b want 0", seen);
        end
        total++;
        if (dut_cmd !== NOOP || dut_in1 !== 8'sd0) begin
            bad++;
            $display("FAIL mid_dut_regs: cmd=%h in1=%h want %h 00", dut_cmd, dut_in1, NOOP);
        end
        req_valid = 4'b1111;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_ptr_reset: got %b want 0001", req_ready);
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fairness();
        test_back_pressure();
        test_bad_opcode();
        test_reset_mid_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
